// File: rtl/rtp_rx_pkg.sv
// Shared constants, state encodings and helpers for the RTP receive depacketizer.
package rtp_rx_pkg;

    localparam int          RTP_HDR_BYTES = 12;
    localparam int          UDP_HDR_BYTES = 8;
    localparam logic [1:0]  RTP_VERSION   = 2'b10;
    localparam logic [15:0] MIN_UDP_LEN   = 16'(RTP_HDR_BYTES + UDP_HDR_BYTES);
    localparam logic [3:0]  HDR_LAST_IDX  = 4'(RTP_HDR_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_PAY  = 3'd2,
        S_TAIL = 3'd3,
        S_DROP = 3'd4
    } parse_state_e;

    typedef enum logic {
        P_FILL = 1'b0,
        P_PLAY = 1'b1
    } play_state_e;

    function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic en);
        if (en && (value != 16'hFFFF)) begin
            sat_inc = value + 16'd1;
        end else begin
            sat_inc = value;
        end
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with registered read port so the storage maps onto block RAM.
module sample_fifo #(
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [15:0]   wr_data,
    input  logic          rd_en,
    output logic [15:0]   rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int        DEPTH     = 2 ** AW;
    localparam logic [AW:0] DEPTH_LVL = {1'b1, {AW{1'b0}}};

    logic [15:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic [15:0]   rd_data_r;
    logic          wr_ok_s;
    logic          rd_ok_s;

    assign full    = (level_r == DEPTH_LVL);
    assign empty   = (level_r == {(AW + 1){1'b0}});
    assign level   = level_r;
    assign rd_data = rd_data_r;
    assign wr_ok_s = wr_en && !full;
    assign rd_ok_s = rd_en && !empty;

    // Storage and read port, no reset so the array stays a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
        if (rd_ok_s) begin
            rd_data_r <= mem_r[rd_ptr_r];
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {(AW + 1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            if (rd_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   level_r <= level_r + {{AW{1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{AW{1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/rtp_rx_depack.sv
// RTP receive depacketizer: validates RTP headers from the UDP byte stream and
// plays 16-bit PCM samples out of a jitter FIFO on each wav_rden request.
module rtp_rx_depack
    import rtp_rx_pkg::*;
#(
    parameter logic [31:0] SSRC    = 32'h12345678,
    parameter int          FIFO_AW = 11,
    parameter int          PREFILL = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             udp_rec_data_valid,
    input  logic [7:0]       udp_rec_rdata,
    input  logic [15:0]      udp_rec_data_length,
    input  logic             wav_rden,
    output logic [15:0]      wav_out_data,
    output logic [FIFO_AW:0] fifo_level,
    output logic [15:0]      pkt_ok_cnt,
    output logic [15:0]      pkt_drop_cnt,
    output logic [15:0]      seq_err_cnt,
    output logic [15:0]      underrun_cnt,
    output logic [15:0]      overflow_cnt
);

    localparam logic [FIFO_AW:0] PREFILL_LVL = (FIFO_AW + 1)'(PREFILL);

    parse_state_e parse_st_r, parse_nxt_s;
    play_state_e  play_st_r, play_nxt_s;

    logic [3:0]  byte_cnt_r;
    logic [15:0] budget_r;
    logic [15:0] seq_r;
    logic [15:0] seq_exp_r;
    logic        seq_seen_r;
    logic [23:0] ssrc_r;
    logic [7:0]  hi_r;
    logic        hi_phase_r;
    logic        out_zero_r;

    logic        hdr_ok_s;
    logic        hdr_last_s;
    logic        ssrc_match_s;
    logic        fifo_wr_s;
    logic        pkt_ok_ev_s;
    logic        pkt_drop_ev_s;
    logic        seq_err_ev_s;
    logic        pop_s;
    logic        underrun_ev_s;
    logic        overflow_ev_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic [15:0] fifo_rd_data_s;

    assign hdr_ok_s     = (udp_rec_data_length >= MIN_UDP_LEN) &&
                          (udp_rec_rdata[7:6] == RTP_VERSION) &&
                          !udp_rec_rdata[4] && (udp_rec_rdata[3:0] == 4'd0);
    assign hdr_last_s   = udp_rec_data_valid && (parse_st_r == S_HDR) && (byte_cnt_r == HDR_LAST_IDX);
    assign ssrc_match_s = ({ssrc_r, udp_rec_rdata} == SSRC);

    // Parse state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parse_st_r <= S_IDLE;
        end else begin
            parse_st_r <= parse_nxt_s;
        end
    end

    // Parse next-state logic; any cycle with valid low ends the packet.
    always_comb begin
        parse_nxt_s = parse_st_r;
        case (parse_st_r)
            S_IDLE: begin
                if (udp_rec_data_valid) begin
                    parse_nxt_s = hdr_ok_s ? S_HDR : S_DROP;
                end else begin
                    parse_nxt_s = S_IDLE;
                end
            end
            S_HDR: begin
                if (!udp_rec_data_valid) begin
                    parse_nxt_s = S_IDLE;
                end else if (hdr_last_s) begin
                    if (!ssrc_match_s) begin
                        parse_nxt_s = S_DROP;
                    end else if (budget_r == 16'd0) begin
                        parse_nxt_s = S_TAIL;
                    end else begin
                        parse_nxt_s = S_PAY;
                    end
                end else begin
                    parse_nxt_s = S_HDR;
                end
            end
            S_PAY: begin
                if (!udp_rec_data_valid) begin
                    parse_nxt_s = S_IDLE;
                end else if (!hi_phase_r && (budget_r < 16'd2)) begin
                    parse_nxt_s = S_TAIL;
                end else if (hi_phase_r && (budget_r == 16'd2)) begin
                    parse_nxt_s = S_TAIL;
                end else begin
                    parse_nxt_s = S_PAY;
                end
            end
            S_TAIL, S_DROP: begin
                if (!udp_rec_data_valid) begin
                    parse_nxt_s = S_IDLE;
                end else begin
                    parse_nxt_s = parse_st_r;
                end
            end
            default: parse_nxt_s = S_IDLE;
        endcase
    end

    // Parse outputs: FIFO write strobe and end-of-packet / sequence events.
    always_comb begin
        fifo_wr_s     = 1'b0;
        pkt_ok_ev_s   = 1'b0;
        pkt_drop_ev_s = 1'b0;
        seq_err_ev_s  = 1'b0;
        case (parse_st_r)
            S_HDR: begin
                pkt_drop_ev_s = !udp_rec_data_valid;
                seq_err_ev_s  = hdr_last_s && ssrc_match_s && seq_seen_r && (seq_r != seq_exp_r);
            end
            S_PAY: begin
                fifo_wr_s   = udp_rec_data_valid && hi_phase_r;
                pkt_ok_ev_s = !udp_rec_data_valid;
            end
            S_TAIL: pkt_ok_ev_s   = !udp_rec_data_valid;
            S_DROP: pkt_drop_ev_s = !udp_rec_data_valid;
            default: begin
                fifo_wr_s     = 1'b0;
                pkt_ok_ev_s   = 1'b0;
                pkt_drop_ev_s = 1'b0;
                seq_err_ev_s  = 1'b0;
            end
        endcase
    end

    // Header capture, payload budget and byte pairing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt_r <= 4'd0;
            budget_r   <= 16'd0;
            seq_r      <= 16'd0;
            seq_exp_r  <= 16'd0;
            seq_seen_r <= 1'b0;
            ssrc_r     <= 24'd0;
            hi_r       <= 8'd0;
            hi_phase_r <= 1'b0;
        end else begin
            case (parse_st_r)
                S_IDLE: begin
                    byte_cnt_r <= 4'd1;
                    budget_r   <= udp_rec_data_length - MIN_UDP_LEN;
                    hi_phase_r <= 1'b0;
                end
                S_HDR: begin
                    if (udp_rec_data_valid) begin
                        byte_cnt_r <= byte_cnt_r + 4'd1;
                        case (byte_cnt_r)
                            4'd2:               seq_r[15:8] <= udp_rec_rdata;
                            4'd3:               seq_r[7:0]  <= udp_rec_rdata;
                            4'd8, 4'd9, 4'd10:  ssrc_r      <= {ssrc_r[15:0], udp_rec_rdata};
                            default:            ssrc_r      <= ssrc_r;
                        endcase
                    end
                    if (hdr_last_s && ssrc_match_s) begin
                        seq_exp_r  <= seq_r + 16'd1;
                        seq_seen_r <= 1'b1;
                    end
                end
                S_PAY: begin
                    if (udp_rec_data_valid && hi_phase_r) begin
                        budget_r   <= budget_r - 16'd2;
                        hi_phase_r <= 1'b0;
                    end else if (udp_rec_data_valid && (budget_r >= 16'd2)) begin
                        hi_r       <= udp_rec_rdata;
                        hi_phase_r <= 1'b1;
                    end
                end
                default: hi_phase_r <= 1'b0;
            endcase
        end
    end

    sample_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr_s),
        .wr_data ({hi_r, udp_rec_rdata}),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level)
    );

    assign pop_s         = wav_rden && (play_st_r == P_PLAY) && !fifo_empty_s;
    assign underrun_ev_s = wav_rden && (play_st_r == P_PLAY) && fifo_empty_s;
    assign overflow_ev_s = fifo_wr_s && fifo_full_s;

    // Playout state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            play_st_r <= P_FILL;
        end else begin
            play_st_r <= play_nxt_s;
        end
    end

    // Playout next-state: wait for the prefill level, fall back on starvation.
    always_comb begin
        play_nxt_s = play_st_r;
        case (play_st_r)
            P_FILL: begin
                if (fifo_level >= PREFILL_LVL) begin
                    play_nxt_s = P_PLAY;
                end else begin
                    play_nxt_s = P_FILL;
                end
            end
            P_PLAY: begin
                if (underrun_ev_s) begin
                    play_nxt_s = P_FILL;
                end else begin
                    play_nxt_s = P_PLAY;
                end
            end
            default: play_nxt_s = P_FILL;
        endcase
    end

    // Playout output: a request that does not pop presents silence until the next request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_zero_r <= 1'b1;
        end else if (wav_rden) begin
            out_zero_r <= !pop_s;
        end
    end

    assign wav_out_data = out_zero_r ? 16'h0000 : fifo_rd_data_s;

    // Saturating status counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_ok_cnt   <= 16'd0;
            pkt_drop_cnt <= 16'd0;
            seq_err_cnt  <= 16'd0;
            underrun_cnt <= 16'd0;
            overflow_cnt <= 16'd0;
        end else begin
            pkt_ok_cnt   <= sat_inc(pkt_ok_cnt, pkt_ok_ev_s);
            pkt_drop_cnt <= sat_inc(pkt_drop_cnt, pkt_drop_ev_s);
            seq_err_cnt  <= sat_inc(seq_err_cnt, seq_err_ev_s);
            underrun_cnt <= sat_inc(underrun_cnt, underrun_ev_s);
            overflow_cnt <= sat_inc(overflow_cnt, overflow_ev_s);
        end
    end

endmodule

// File: tb/tb_rtp_rx_depack.sv
// Self-checking bench for rtp_rx_depack: packet table plus hand-written playout,
// back-to-back and overflow sequences, with a sample scoreboard queue.
module tb_rtp_rx_depack;

    localparam int          PREFILL = 480;
    localparam int          DEPTH   = 2048;
    localparam int          ALL     = 99999;
    localparam logic [31:0] GOOD    = 32'h12345678;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        udp_rec_data_valid;
    logic [7:0]  udp_rec_rdata;
    logic [15:0] udp_rec_data_length;
    logic        wav_rden;
    logic [15:0] wav_out_data;
    logic [11:0] fifo_level;
    logic [15:0] pkt_ok_cnt, pkt_drop_cnt, seq_err_cnt, underrun_cnt, overflow_cnt;

    always #5 clk = ~clk;

    rtp_rx_depack dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .udp_rec_data_valid  (udp_rec_data_valid),
        .udp_rec_rdata       (udp_rec_rdata),
        .udp_rec_data_length (udp_rec_data_length),
        .wav_rden            (wav_rden),
        .wav_out_data        (wav_out_data),
        .fifo_level          (fifo_level),
        .pkt_ok_cnt          (pkt_ok_cnt),
        .pkt_drop_cnt        (pkt_drop_cnt),
        .seq_err_cnt         (seq_err_cnt),
        .underrun_cnt        (underrun_cnt),
        .overflow_cnt        (overflow_cnt)
    );

    typedef struct {
        logic [15:0] len;
        logic [7:0]  b0;
        logic [15:0] seq;
        logic [31:0] ssrc;
        int          npay;
        int          burst;
        logic [15:0] first;
        int          d_ok;
        int          d_drop;
        int          d_seq;
    } vec_t;

    vec_t        vt[16];
    logic [15:0] sb_q[$];
    bit          m_play;
    int          m_ok, m_drop, m_seq, m_under, m_ovf;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] last_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one burst (possibly truncated) and pushes accepted samples to the scoreboard.
    task automatic send_pkt(input logic [15:0] len, input logic [7:0] b0, input logic [15:0] seq,
                            input logic [31:0] ssrc, input int npay, input int burst,
                            input bit accept, input logic [15:0] first, input int gap);
        logic [7:0]  bytes[$];
        logic [95:0] hdr;
        logic [15:0] s;
        int          nb;
        hdr = {b0, 8'h60, seq, 32'h0000_0000, ssrc};
        for (int i = 0; i < 12; i++) bytes.push_back(hdr[95 - 8*i -: 8]);
        for (int k = 0; k < npay; k++) begin
            s = first + 16'(k / 2);
            bytes.push_back((k % 2 == 0) ? s[15:8] : s[7:0]);
        end
        nb = (burst < bytes.size()) ? burst : bytes.size();
        for (int i = 0; i < nb; i++) begin
            udp_rec_data_valid  = 1'b1;
            udp_rec_rdata       = bytes[i];
            udp_rec_data_length = len;
            @(posedge clk); #1;
        end
        udp_rec_data_valid = 1'b0;
        udp_rec_rdata      = 8'h00;
        if (accept) begin
            for (int k = 0; (2*k + 1 < npay) && (12 + 2*k + 1 < nb); k++) begin
                if (sb_q.size() < DEPTH) sb_q.push_back(first + 16'(k));
                else m_ovf++;
            end
        end
        repeat (gap) @(posedge clk);
        #1;
    endtask

    // Issues one wav_rden pulse and checks the sample one cycle later against the model.
    task automatic rden_check(input string name);
        logic [15:0] exp;
        if (!m_play && sb_q.size() >= PREFILL) m_play = 1'b1;
        if (m_play && sb_q.size() > 0) begin
            exp = sb_q.pop_front();
        end else begin
            exp = 16'h0000;
            if (m_play) begin
                m_under++;
                m_play = 1'b0;
            end
        end
        last_exp = exp;
        wav_rden = 1'b1;
        @(posedge clk); #1;
        wav_rden = 1'b0;
        @(negedge clk);
        check(name, wav_out_data, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // len, b0, seq, ssrc, npay, burst, first, d_ok, d_drop, d_seq
        vt[0]  = '{16'd24,  8'h80, 16'd1,    32'hDEADBEEF, 4,   ALL, 16'h0000, 0, 1, 0};
        vt[1]  = '{16'd24,  8'h40, 16'd1,    GOOD,         4,   ALL, 16'h0000, 0, 1, 0};
        vt[2]  = '{16'd15,  8'h80, 16'd1,    GOOD,         4,   ALL, 16'h0000, 0, 1, 0};
        vt[3]  = '{16'd24,  8'h90, 16'd1,    GOOD,         4,   ALL, 16'h0000, 0, 1, 0};
        vt[4]  = '{16'd24,  8'h81, 16'd1,    GOOD,         4,   ALL, 16'h0000, 0, 1, 0};
        vt[5]  = '{16'd24,  8'h80, 16'h1234, GOOD,         4,   6,   16'h0000, 0, 1, 0};
        vt[6]  = '{16'd980, 8'h80, 16'd5,    GOOD,         960, ALL, 16'h0001, 1, 0, 0};
        vt[7]  = '{16'd27,  8'h80, 16'd6,    GOOD,         7,   ALL, 16'hA000, 1, 0, 0};
        vt[8]  = '{16'd20,  8'h80, 16'd7,    GOOD,         0,   ALL, 16'h0000, 1, 0, 0};
        vt[9]  = '{16'd20,  8'h80, 16'd8,    GOOD,         0,   ALL, 16'h0000, 1, 0, 0};
        vt[10] = '{16'd20,  8'h80, 16'd10,   GOOD,         0,   ALL, 16'h0000, 1, 0, 1};
        vt[11] = '{16'd20,  8'h80, 16'hFFFF, GOOD,         0,   ALL, 16'h0000, 1, 0, 1};
        vt[12] = '{16'd20,  8'h80, 16'h0000, GOOD,         0,   ALL, 16'h0000, 1, 0, 0};
        vt[13] = '{16'd20,  8'hA0, 16'd1,    GOOD,         0,   ALL, 16'h0000, 1, 0, 0};
        vt[14] = '{16'd20,  8'h80, 16'h5555, 32'h12345679, 0,   ALL, 16'h0000, 0, 1, 0};
        vt[15] = '{16'd20,  8'h80, 16'd2,    GOOD,         0,   ALL, 16'h0000, 1, 0, 0};

        m_play = 1'b0; m_ok = 0; m_drop = 0; m_seq = 0; m_under = 0; m_ovf = 0;
        last_exp = 16'h0000;
        rst_n = 1'b0;
        udp_rec_data_valid = 1'b0;
        udp_rec_rdata = 8'h00;
        udp_rec_data_length = 16'd0;
        wav_rden = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        check("reset wav_out_data", wav_out_data, 16'h0000);
        check("reset fifo_level",   fifo_level,   12'd0);
        check("reset pkt_ok_cnt",   pkt_ok_cnt,   16'd0);
        check("reset pkt_drop_cnt", pkt_drop_cnt, 16'd0);
        check("reset seq_err_cnt",  seq_err_cnt,  16'd0);
        check("reset underrun_cnt", underrun_cnt, 16'd0);
        check("reset overflow_cnt", overflow_cnt, 16'd0);

        for (int i = 0; i < 16; i++) begin
            send_pkt(vt[i].len, vt[i].b0, vt[i].seq, vt[i].ssrc, vt[i].npay, vt[i].burst,
                     vt[i].d_ok != 0, vt[i].first, 3);
            m_ok   += vt[i].d_ok;
            m_drop += vt[i].d_drop;
            m_seq  += vt[i].d_seq;
            check($sformatf("vec%0d pkt_ok_cnt", i),   pkt_ok_cnt,   m_ok);
            check($sformatf("vec%0d pkt_drop_cnt", i), pkt_drop_cnt, m_drop);
            check($sformatf("vec%0d seq_err_cnt", i),  seq_err_cnt,  m_seq);
            check($sformatf("vec%0d fifo_level", i),   fifo_level,   sb_q.size());
        end

        // Playout: first three samples, hold, then drain into an underrun.
        for (int i = 0; i < 3; i++) rden_check($sformatf("first sample %0d", i));
        repeat (5) @(posedge clk);
        #1;
        check("hold wav_out_data", wav_out_data, last_exp);
        for (int i = 0; i < 481; i++) rden_check($sformatf("drain %0d", i));
        check("underrun_cnt", underrun_cnt, m_under);
        for (int i = 0; i < 2; i++) rden_check($sformatf("refill silence %0d", i));
        check("fifo_level after drain", fifo_level, sb_q.size());

        // Overflow: 2050 samples into an empty FIFO with no reads.
        for (int i = 0; i < 4; i++)
            send_pkt(16'd980, 8'h80, 16'(3 + i), GOOD, 960, ALL, 1'b1, 16'(16'h1000 + 480*i), 3);
        send_pkt(16'd280, 8'h80, 16'd7, GOOD, 260, ALL, 1'b1, 16'h2000, 3);
        check("overflow fifo_level", fifo_level, sb_q.size());
        check("overflow_cnt", overflow_cnt, m_ovf);
        m_ok += 5;
        check("overflow pkt_ok_cnt", pkt_ok_cnt, m_ok);

        // Back-to-back bursts separated by a single idle cycle.
        send_pkt(16'd24, 8'h80, 16'd8, GOOD, 4, ALL, 1'b1, 16'hB000, 1);
        send_pkt(16'd24, 8'h80, 16'd9, GOOD, 4, ALL, 1'b1, 16'hB100, 3);
        m_ok += 2;
        check("b2b pkt_ok_cnt", pkt_ok_cnt, m_ok);
        check("b2b seq_err_cnt", seq_err_cnt, m_seq);
        check("b2b overflow_cnt", overflow_cnt, m_ovf);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rtp_rx_depack.md
# rtp_rx_depack

Receive-side RTP depacketizer for the audio loop. Consumes the UDP receive byte stream from the Ethernet core (udp_rec_data_valid / udp_rec_rdata / udp_rec_data_length), validates the RTP header, and writes the 16-bit PCM payload into a sample jitter FIFO. It feeds `wav_out_data` to the WM8731 playback path whenever `wav_rden` pulses. It is the downstream mirror of the `net_top` transmit packetizer.

## Interface
- `SSRC`, 32'h12345678, accepted stream identifier; any other SSRC is dropped.
- `FIFO_AW`, 11, FIFO address width; depth = 2**FIFO_AW samples (2048).
- `PREFILL`, 480, FIFO level (samples) required before playout starts or resumes.

Ports:
- `clk`  in  1  system clock; all ports are synchronous to it (CDC is done upstream).
- `rst_n`  in  1  reset, synchronous, active-low.
- `udp_rec_data_valid`  in  1  high for one cycle per received UDP payload byte; a packet is one contiguous valid burst.
- `udp_rec_rdata`  in  8  payload byte.
- `udp_rec_data_length`  in  16  UDP length field (payload + 8); stable for the whole burst.
- `wav_rden`  in  1  one-cycle playback sample request.
- `wav_out_data`  out  16  current playback sample.
- `fifo_level`  out  FIFO_AW+1  samples buffered.
- `pkt_ok_cnt`, `pkt_drop_cnt`, `seq_err_cnt`, `underrun_cnt`, `overflow_cnt`  out  16 each  saturating status counters.

## Operation
- Parse FSM states:
  - S_IDLE, on the first valid byte:
    - If length < 20 (UDP 8 + RTP 12), or byte0[7:6] != 2'b10, or byte0[4] (X) = 1, or byte0[3:0] (CC) != 0: go to S_DROP.
    - Otherwise: go to S_HDR, byte counter = 1, payload budget = length − 20.
  - S_HDR, bytes 1..11:
    - Capture sequence number from bytes 2–3 and SSRC from bytes 8–11.
    - At byte 11: SSRC mismatch → S_DROP; match → S_PAY. If budget = 0, go to S_TAIL instead.
  - S_PAY: bytes pair big-endian (high byte first).
    - On the low byte, write {hi, lo} to the FIFO and decrement the budget by 2.
    - Budget reaching 0 → S_TAIL. A trailing odd byte is discarded.
  - S_TAIL / S_DROP: ignore bytes until valid is low.
- End of packet is the first cycle with valid low, after which the FSM returns to S_IDLE.
  - Packet ending in S_PAY or S_TAIL: `pkt_ok_cnt`++.
  - Packet ending in S_DROP, or truncated in S_HDR (valid falls before byte 11): `pkt_drop_cnt`++.
  - Truncated payload already written is kept.
- Valid re-asserting in the cycle right after a deassert starts a new packet.
- Sequence check, on each accepted header at byte 11:
  - After the first accepted packet, seq != expected → `seq_err_cnt`++; the packet is still accepted.
  - Expected = seq + 1 mod 2^16, so 16'hFFFF is followed by 16'h0000 with no error.
- FIFO write while full: the sample is discarded and `overflow_cnt`++. Fullness uses the registered level, so a same-cycle pop does not make room.
- Playout FSM:
  - P_FILL: each `wav_rden` drives 0. Transition to P_PLAY when `fifo_level` ≥ PREFILL.
  - P_PLAY: `wav_rden` pops one sample.
  - Underrun: `wav_rden` with the FIFO empty drives 0, `underrun_cnt`++, and returns to P_FILL.
- Simultaneous write and pop: both take effect and the level is unchanged.
- All counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - `wav_out_data` = 0, `fifo_level` = 0, all counters = 0.
  - FSMs in S_IDLE / P_FILL; sequence-check history cleared.
- Reset mid-packet: the rest of that burst is parsed from S_IDLE starting at whatever byte is present. Upstream guarantees reset is not released mid-burst.
- FIFO write occurs in the same cycle as the valid low-byte; `fifo_level` reflects it next cycle.
- `wav_out_data` updates exactly 1 cycle after `wav_rden` (synchronous-read RAM) and holds until the next `wav_rden`.
- Accepts one byte per cycle, back-to-back, with no backpressure.

## Structure
- Package `rtp_rx_pkg` holds:
  - RTP_HDR_BYTES = 12, UDP_HDR_BYTES = 8, RTP_VERSION = 2'b10.
  - Parse-state and playout-state encodings.
- Sub-module `sample_fifo`: synchronous single-clock FIFO (16-bit × 2**FIFO_AW, inferred RAM) with `full`, `empty` and `level` outputs.
- Top level contains the parse FSM, sequence tracker, playout FSM and counters.

## Test plan
- Valid packet: length 980, SSRC 0x12345678, seq 5, payload 0x0001..0x01E0 (480 samples).
  - → `pkt_ok_cnt` = 1, `fifo_level` = 480, P_PLAY.
  - Next 3 `wav_rden` pulses → 0x0001, 0x0002, 0x0003, each 1 cycle after its pulse.
- SSRC 0xDEADBEEF, then byte0 = 0x40 (version 1), then length 15.
  - → `pkt_drop_cnt` = 3, `fifo_level` = 0.
- Sequence numbers 7, 8, 10, then 0xFFFF, 0x0000 → `seq_err_cnt` = 2 (the 8→10 gap and the 10→0xFFFF jump); the 0xFFFF→0x0000 wrap is not counted.
- Prefill 480 samples, then 481 `wav_rden` pulses with no new packets.
  - → the 481st returns 0, `underrun_cnt` = 1, state P_FILL.
  - Further pulses return 0 until 480 more samples arrive.
- Write 2050 samples with no reads → `fifo_level` = 2048, `overflow_cnt` = 2.
- Odd payload length 7 bytes → 3 samples written, last byte dropped; `pkt_ok_cnt`++.
- Valid falls at header byte 6 → `pkt_drop_cnt`++, no write.
